// File: rtl/lut_layer_sequencer_if.sv
// Bundle of the sequencer's config, input-vector and result handshakes.
// master = the block that feeds the sequencer; slave = the sequencer itself.
interface lut_layer_sequencer_if #(
  parameter int NEURONS = 8,
  parameter int FANIN   = 8
);
  logic                        cfg_we;
  logic [$clog2(NEURONS)-1:0]  cfg_neuron;
  logic [FANIN-1:0]            cfg_addr;
  logic                        cfg_data;
  logic                        cfg_ready;
  logic                        s_valid;
  logic [NEURONS*FANIN-1:0]    s_data;
  logic                        s_ready;
  logic                        m_valid;
  logic [NEURONS-1:0]          m_data;
  logic                        m_ready;

  modport master (
    output cfg_we, cfg_neuron, cfg_addr, cfg_data, s_valid, s_data, m_ready,
    input  cfg_ready, s_ready, m_valid, m_data
  );

  modport slave (
    input  cfg_we, cfg_neuron, cfg_addr, cfg_data, s_valid, s_data, m_ready,
    output cfg_ready, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Layer of 1-bit LUT neurons sharing a single lookup path: one neuron is
// evaluated per cycle, the result vector is held until the consumer takes it.
module lut_layer_sequencer #(
  parameter int NEURONS = 8,
  parameter int FANIN   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  lut_layer_sequencer_if.slave   bus,
  output logic                   busy
);
  localparam int NW    = $clog2(NEURONS);
  localparam int DEPTH = 1 << FANIN;
  localparam logic [NW:0]   NEURONS_EXT = (NW+1)'(NEURONS);
  localparam logic [NW-1:0] LAST_IDX    = NW'(NEURONS - 1);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [NW-1:0]            idx_q, idx_d;
  logic [NEURONS-1:0]       result_q, result_d;
  logic [NEURONS*FANIN-1:0] in_q, in_d;

  // Truth tables survive reset; there is deliberately no clear path.
  logic [DEPTH-1:0]         table_q [NEURONS];

  logic [FANIN-1:0]         slice [NEURONS];
  logic                     idle;
  logic                     cfg_hit;
  logic                     lut_bit;

  for (genvar g = 0; g < NEURONS; g++) begin : g_slice
    assign slice[g] = in_q[g*FANIN +: FANIN];
  end

  assign idle    = (state_q == IDLE);
  assign cfg_hit = bus.cfg_we && idle && ({1'b0, bus.cfg_neuron} < NEURONS_EXT);
  assign lut_bit = table_q[idx_q][slice[idx_q]];

  // A write accepted on the same edge as an input accept lands before the
  // first EVAL read, so the new entry is seen by that evaluation.
  always_ff @(posedge clk) begin
    if (cfg_hit) begin
      table_q[bus.cfg_neuron][bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    in_d     = in_q;
    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          in_d     = bus.s_data;
          result_d = '0;
          idx_d    = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        result_d[idx_q] = lut_bit;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = HOLD;
        end else begin
          idx_d = idx_q + NW'(1);
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      result_q <= '0;
      in_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      in_q     <= in_d;
    end
  end

  assign bus.s_ready   = idle;
  assign bus.cfg_ready = idle;
  assign bus.m_valid   = (state_q == HOLD);
  assign bus.m_data    = result_q;
  assign busy          = !idle;
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer with NEURONS=4, FANIN=8.
module tb_lut_layer_sequencer;
  localparam int N = 4;
  localparam int F = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  lut_layer_sequencer_if #(.NEURONS(N), .FANIN(F)) bus();

  lut_layer_sequencer #(.NEURONS(N), .FANIN(F)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    string          name;
    logic [N*F-1:0] sdata;
    logic [N-1:0]   exp;
  } vec_t;

  vec_t va [4];
  vec_t vb [5];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int n, input int a, input logic d);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = 2'(n);
    bus.cfg_addr   = 8'(a);
    bus.cfg_data   = d;
    tick();
    bus.cfg_we     = 1'b0;
  endtask

  task automatic start(input logic [N*F-1:0] d);
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.m_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: m_valid timeout, got 0, expected 1", name);
    end
  endtask

  task automatic release_result();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic eval(input string name, input logic [N*F-1:0] d, input logic [N-1:0] exp);
    logic ok;
    start(d);
    wait_valid(name, ok);
    if (ok) check(name, 32'(bus.m_data), 32'(exp));
    release_result();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},   32'(bus.s_ready),   32'd1);
    check({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_m_valid"},   32'(bus.m_valid),   32'd0);
    check({tag, "_m_data"},    32'(bus.m_data),    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic [7:0] av;
    int hi_cnt;

    // Tables A: neuron0 = 1 only at 0, others all ones.
    va[0] = '{"a_zero",    32'h0000_0000, 4'b1111};
    va[1] = '{"a_n0_01",   32'h0000_0001, 4'b1110};
    va[2] = '{"a_hi_ones", 32'hFFFF_FF00, 4'b1111};
    va[3] = '{"a_n0_ff",   32'h0000_00FF, 4'b1110};
    // Tables B: neuron i outputs bit i of its own slice.
    vb[0] = '{"b_onehot",  32'h0804_0201, 4'b1111};
    vb[1] = '{"b_inv",     32'hF7FB_FDFE, 4'b0000};
    vb[2] = '{"b_0101",    32'h0004_0001, 4'b0101};
    vb[3] = '{"b_1010",    32'h0800_0200, 4'b1010};
    vb[4] = '{"b_1100",    32'h08FF_010E, 4'b1100};

    bus.cfg_we = 1'b0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("por");

    for (int n = 0; n < N; n++)
      for (int a = 0; a < (1 << F); a++)
        cfg_write(n, a, (n == 0) ? (a == 0) : 1'b1);

    for (int i = 0; i < 4; i++) eval(va[i].name, va[i].sdata, va[i].exp);

    // Latency and hold behaviour.
    start('0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("lat_busy_%0d", k),   32'(busy),        32'd1);
      check($sformatf("lat_mvalid_%0d", k), 32'(bus.m_valid), 32'd0);
      tick();
    end
    check("lat_mvalid_on", 32'(bus.m_valid), 32'd1);
    check("lat_mdata",     32'(bus.m_data),  32'hF);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_mdata_%0d", k),  32'(bus.m_data),  32'hF);
      check($sformatf("hold_sready_%0d", k), 32'(bus.s_ready), 32'd0);
      check($sformatf("hold_mvalid_%0d", k), 32'(bus.m_valid), 32'd1);
    end
    bus.s_valid = 1'b0;
    release_result();
    check("hold_release_sready", 32'(bus.s_ready), 32'd1);
    check("hold_release_busy",   32'(busy),        32'd0);

    // Config write during EVAL is dropped.
    start('0);
    check("eval_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    cfg_write(3, 0, 1'b0);
    wait_valid("eval_wr_ignored", ok);
    if (ok) check("eval_wr_ignored", 32'(bus.m_data), 32'hF);
    release_result();
    eval("eval_wr_retained", '0, 4'b1111);

    // Reset mid-evaluation at idx 2.
    start('0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_eval");
    hi_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.m_valid !== 1'b0) hi_cnt++;
      tick();
    end
    check("rst_eval_no_mvalid", 32'(hi_cnt), 32'd0);
    eval("rst_eval_rerun", '0, 4'b1111);

    // Reset while holding a result.
    start('0);
    wait_valid("rst_hold_reach", ok);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("rst_hold");

    // Write and accept on the same edge.
    bus.cfg_we = 1'b1; bus.cfg_neuron = 2'd1; bus.cfg_addr = 8'h00; bus.cfg_data = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = '0;
    tick();
    bus.cfg_we = 1'b0;
    bus.s_valid = 1'b0;
    wait_valid("same_edge_wr", ok);
    if (ok) check("same_edge_wr", 32'(bus.m_data), 32'hD);
    release_result();

    for (int n = 0; n < N; n++)
      for (int a = 0; a < (1 << F); a++) begin
        av = 8'(a);
        cfg_write(n, a, av[n]);
      end

    for (int i = 0; i < 5; i++) eval(vb[i].name, vb[i].sdata, vb[i].exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
